// File: rtl/keypad_scanner_pkg.sv
// Shared types for the keypad scanner: FSM state encoding and the legacy
// 4x4 key index to digit translation.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  function automatic logic [3:0] keypad_map(input logic [3:0] code);
    logic [3:0] digit;
    case (code)
      4'd0:    digit = 4'd1;
      4'd1:    digit = 4'd2;
      4'd2:    digit = 4'd3;
      4'd3:    digit = 4'd10;
      4'd4:    digit = 4'd4;
      4'd5:    digit = 4'd5;
      4'd6:    digit = 4'd6;
      4'd7:    digit = 4'd11;
      4'd8:    digit = 4'd7;
      4'd9:    digit = 4'd8;
      4'd10:   digit = 4'd9;
      4'd11:   digit = 4'd12;
      4'd12:   digit = 4'd14;
      4'd13:   digit = 4'd0;
      4'd14:   digit = 4'd15;
      default: digit = 4'd13;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Saturating run-length counter: done pulses on the CYCLES-th consecutive
// clock with en high; any clock with en low restarts the run.
module keypad_debounce #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(CYCLES)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb done = en && (cnt == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with debounced press/release and a valid/ready event
// output. Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 500000,
  parameter int DEBOUNCE_CYCLES = 100000
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [COLS-1:0]                 colunas,
  input  logic [ROWS-1:0]                 linhas,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic                            key_held,
  output logic                            overrun
);

  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);

  state_t            state;
  logic [ROWS-1:0]   rows_meta;
  logic [ROWS-1:0]   rows;
  logic [COL_W-1:0]  col_idx;
  logic [COL_W-1:0]  next_col;
  logic [ROW_W-1:0]  row_idx;
  logic [ROW_W-1:0]  low_row;
  logic [SCAN_W-1:0] scan_cnt;
  logic [CODE_W-1:0] new_code;
  logic              all_high;
  logic              row_low;
  logic              deb_en;
  logic              deb_done;
  logic              rep_event;
  logic              ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta <= '1;
      rows      <= '1;
    end else begin
      rows_meta <= linhas;
      rows      <= rows_meta;
    end
  end

  always_comb begin
    colunas          = '1;
    colunas[col_idx] = 1'b0;
  end

  always_comb begin
    low_row = '0;
    for (int unsigned i = ROWS; i > 0; i--) begin
      if (!rows[i-1]) low_row = ROW_W'(i - 1);
    end
  end

  always_comb begin
    all_high = &rows;
    row_low  = !rows[row_idx];
    next_col = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
    new_code = CODE_W'(int'(row_idx) * COLS + int'(col_idx));
    deb_en   = ((state == DEBOUNCE) && row_low) || ((state == RELEASE) && all_high);
    ev       = ((state == DEBOUNCE) && deb_done) || rep_event;
  end

  keypad_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (deb_en),
    .done (deb_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SCAN;
      col_idx  <= '0;
      row_idx  <= '0;
      scan_cnt <= '0;
      key_held <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (!all_high) begin
            state    <= DEBOUNCE;
            row_idx  <= low_row;
            scan_cnt <= '0;
          end else if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            col_idx  <= next_col;
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!row_low) begin
            state <= SCAN;
          end else if (deb_done) begin
            state    <= HELD;
            key_held <= 1'b1;
          end
        end
        HELD: begin
          if (all_high) state <= RELEASE;
        end
        RELEASE: begin
          if (!all_high) begin
            state <= HELD;
          end else if (deb_done) begin
            state    <= SCAN;
            key_held <= 1'b0;
            col_idx  <= next_col;
            scan_cnt <= '0;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_last;
  logic             rep_armed;

  always_comb begin
    rep_last  = rep_armed ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1);
    rep_event = (state == HELD) && (rep_cnt == rep_last);
  end

  // Repeat timing pauses while release is being confirmed, so a bounce back
  // into HELD resumes the same repeat schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (state == HELD) begin
      if (rep_event) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end else if (state != RELEASE) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end
  end
`else
  always_comb rep_event = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (ev && key_valid && !key_ready) begin
        overrun <= 1'b1;
      end else if (ev) begin
        key_code  <= new_code;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (4x4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8);
// compile with KEYPAD_REPEAT_EN defined to also exercise auto-repeat.
module tb_keypad_scanner;
  import keypad_pkg::keypad_map;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SCAN_N = 4;
  localparam int DEB_N  = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_D  = 20;
  localparam int REP_R  = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] colunas;
  logic [3:0] linhas = 4'hF;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       overrun;

  keypad_scanner #(
    .ROWS(ROWS),
    .COLS(COLS),
    .SCAN_CYCLES(SCAN_N),
    .DEBOUNCE_CYCLES(DEB_N)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY(REP_D),
    .REPEAT_RATE(REP_R)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .colunas  (colunas),
    .linhas   (linhas),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 scanning, 1 confirming press, 2 holding, 3 confirming release.
  int         m_mode, m_base, m_elapsed, m_col, m_row, m_run, m_held_cyc;
  logic [3:0] m_s1, m_s2, m_code;
  logic       m_valid, m_over;

  function automatic int cur_col();
    return (m_mode == 0) ? (m_base + m_elapsed / SCAN_N) % COLS : m_col;
  endfunction

  function automatic int lowest_low(input logic [3:0] r);
    for (int i = 0; i < ROWS; i++) if (!r[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit         ev;
    bit         quiet;
    logic [3:0] r;
    if (!rst_n) begin
      m_mode = 0; m_base = 0; m_elapsed = 0; m_col = 0; m_row = 0;
      m_run = 0; m_held_cyc = 0; m_s1 = 4'hF; m_s2 = 4'hF;
      m_code = 4'h0; m_valid = 1'b0; m_over = 1'b0;
    end else begin
      ev    = 1'b0;
      r     = m_s2;
      quiet = (r == 4'hF);
      case (m_mode)
        0: if (!quiet) begin
             m_col = cur_col(); m_row = lowest_low(r);
             m_mode = 1; m_run = 0; m_held_cyc = 0;
           end else m_elapsed++;
        1: if (r[m_row]) begin
             m_mode = 0; m_base = m_col; m_elapsed = 0;
           end else begin
             m_run++;
             if (m_run == DEB_N) begin m_mode = 2; ev = 1'b1; end
           end
        2: begin
`ifdef KEYPAD_REPEAT_EN
             m_held_cyc++;
             if (m_held_cyc == REP_D || (m_held_cyc > REP_D && (m_held_cyc - REP_D) % REP_R == 0))
               ev = 1'b1;
`endif
             if (quiet) begin m_mode = 3; m_run = 0; end
           end
        default: if (!quiet) m_mode = 2;
           else begin
             m_run++;
             if (m_run == DEB_N) begin
               m_mode = 0; m_base = (m_col + 1) % COLS; m_elapsed = 0;
             end
           end
      endcase
      m_over = 1'b0;
      if (ev && m_valid && !key_ready) m_over = 1'b1;
      else if (ev) begin m_valid = 1'b1; m_code = 4'(m_row * COLS + m_col); end
      else if (m_valid && key_ready) m_valid = 1'b0;
      m_s2 = m_s1;
      m_s1 = linhas;
    end
  end

  always @(negedge clk) begin
    logic [3:0] ecol;
    ecol = ~(4'b0001 << cur_col());
    check("colunas", colunas, ecol);
    check("key_valid", key_valid, m_valid);
    check("key_code", key_code, m_code);
    check("key_held", key_held, (m_mode == 2 || m_mode == 3));
    check("overrun", overrun, m_over);
  end

  int         accepted = 0;
  int         overruns = 0;
  logic [3:0] acc_code = 4'h0;
  always @(negedge clk) begin
    if (key_valid && key_ready) begin accepted++; acc_code = key_code; end
    if (overrun) overruns++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_col_start(input int c);
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 0 && cur_col() == c && m_elapsed % SCAN_N == 0) return;
      tick(1);
    end
    check("wait_col_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat [4];
    int         a0, o0;
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

    check("map0", keypad_map(4'd0), 4'd1);
    check("map3", keypad_map(4'd3), 4'd10);
    check("map9", keypad_map(4'd9), 4'd8);
    check("map12", keypad_map(4'd12), 4'd14);
    check("map13", keypad_map(4'd13), 4'd0);
    check("map15", keypad_map(4'd15), 4'd13);

    tick(2);
    check("rst_colunas", colunas, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Idle scan sequence
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("scan_seq", colunas, pat[(i / 4) % 4]);
    end
    check("idle_no_event", key_valid, 0);

    // Single press row 2 on column 1
    key_ready = 1'b1;
    wait_col_start(1);
    a0 = accepted;
    linhas = 4'b1011;
    tick(20);
    linhas = 4'hF;
    tick(5);
    check("held_after_release", key_held, 1);
    tick(10);
    check("held_cleared", key_held, 0);
    tick(15);
    check("press_events", accepted - a0, 1);
    check("press_code", acc_code, 9);

    // Bouncing row 2 on column 2
    wait_col_start(2);
    a0 = accepted;
    repeat (3) begin
      linhas = 4'b1011; tick(5);
      linhas = 4'hF;    tick(1);
    end
    check("bounce_no_event", accepted - a0, 0);
    linhas = 4'b1011; tick(14);
    linhas = 4'hF;    tick(30);
    check("bounce_events", accepted - a0, 1);
    check("bounce_code", acc_code, 10);

    // Rows 1 and 3 together on column 0: lowest row wins
    wait_col_start(0);
    a0 = accepted;
    linhas = 4'b0101; tick(14);
    linhas = 4'hF;    tick(30);
    check("multi_events", accepted - a0, 1);
    check("multi_code", acc_code, 4);

    // Two presses without ready
    key_ready = 1'b0;
    o0 = overruns;
    wait_col_start(3);
    linhas = 4'b1110; tick(14);
    linhas = 4'hF;    tick(25);
    wait_col_start(1);
    linhas = 4'b1101; tick(14);
    linhas = 4'hF;    tick(25);
    check("ovr_pulses", overruns - o0, 1);
    check("ovr_valid", key_valid, 1);
    check("ovr_code", key_code, 3);
    a0 = accepted;
    key_ready = 1'b1;
    tick(2);
    check("ovr_handshake", accepted - a0, 1);
    check("ovr_acc_code", acc_code, 3);
    check("ovr_cleared", key_valid, 0);

    // Reset four clocks into debounce
    wait_col_start(2);
    a0 = accepted;
    linhas = 4'b0111;
    for (int i = 0; i < 20 && m_mode != 1; i++) tick(1);
    check("reached_debounce", m_mode, 1);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_colunas", colunas, 4'b1110);
    check("arst_valid", key_valid, 0);
    check("arst_held", key_held, 0);
    check("arst_code", key_code, 0);
    check("arst_overrun", overrun, 0);
    linhas = 4'hF;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    check("arst_no_event", accepted - a0, 0);

`ifdef KEYPAD_REPEAT_EN
    wait_col_start(1);
    a0 = accepted;
    linhas = 4'b1011; tick(45);
    linhas = 4'hF;    tick(30);
    check("repeat_events", accepted - a0, 3);
`endif

    // Randomised row activity and consumer back-pressure
    for (int n = 0; n < 60; n++) begin
      int dur;
      linhas = 4'($urandom_range(0, 15));
      dur = $urandom_range(1, 25);
      for (int k = 0; k < dur; k++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
      linhas = 4'hF;
      dur = $urandom_range(1, 25);
      for (int k = 0; k < dur; k++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    key_ready = 1'b1;
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
